// File: rtl/panel_button_conditioner_if.sv
// Front-panel pushbutton bundle: raw active-low pins in, conditioned level/pulse outputs back.
// "rel" carries the release pulse ("release" is a reserved word).
interface panel_button_conditioner_if #(
  parameter int unsigned NBTN = 3
);
  logic [NBTN-1:0] nBtn;
  logic [NBTN-1:0] level;
  logic [NBTN-1:0] press;
  logic [NBTN-1:0] rel;
  logic [NBTN-1:0] hold;

  modport master (output nBtn, input level, press, rel, hold);
  modport slave  (input nBtn, output level, press, rel, hold);
endinterface

// File: rtl/panel_button_conditioner.sv
// Per-button synchroniser, debounce FSM and press/release/long-hold pulse generator
// feeding the PDP-8 panel inputs.
module panel_button_conditioner #(
  parameter int unsigned NBTN            = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned LONG_CYCLES     = 25000000
) (
  input  logic                      clk,
  input  logic                      nReset,
  panel_button_conditioner_if.slave bus
);

  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HSAT  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] HFIRE = HW'(LONG_CYCLES - 1);
  localparam bit HOLD_EN = (LONG_CYCLES != 0);

  typedef enum logic [1:0] {StIdle, StPressWait, StPressed, StReleaseWait} state_e;

  logic [NBTN-1:0] sync1_q, sync2_q, s;
  state_e          state_q [NBTN];
  state_e          state_d [NBTN];
  logic [DW-1:0]   dcnt_q  [NBTN];
  logic [DW-1:0]   dcnt_d  [NBTN];
  logic [HW-1:0]   hcnt_q  [NBTN];
  logic [HW-1:0]   hcnt_d  [NBTN];
  logic [NBTN-1:0] fired_q, fired_d;
  logic [NBTN-1:0] level_q, level_d;
  logic [NBTN-1:0] press_q, press_d;
  logic [NBTN-1:0] rel_q, rel_d;
  logic [NBTN-1:0] hold_q, hold_d;

  assign s = ~sync2_q;

  always_comb begin
    for (int i = 0; i < NBTN; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];
      hcnt_d[i]  = hcnt_q[i];
    end
    fired_d = fired_q;
    level_d = level_q;
    press_d = '0;
    rel_d   = '0;
    hold_d  = '0;

    for (int i = 0; i < NBTN; i++) begin
      unique case (state_q[i])
        StIdle: begin
          if (s[i]) begin
            state_d[i] = StPressWait;
            dcnt_d[i]  = '0;
          end
        end
        StPressWait: begin
          if (!s[i]) begin
            state_d[i] = StIdle;
            dcnt_d[i]  = '0;
          end else if (dcnt_q[i] == DLAST) begin
            state_d[i]  = StPressed;
            level_d[i]  = 1'b1;
            press_d[i]  = 1'b1;
            hcnt_d[i]   = '0;
            fired_d[i]  = 1'b0;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
        end
        StPressed: begin
          if (!s[i]) begin
            state_d[i] = StReleaseWait;
            dcnt_d[i]  = '0;
          end else begin
            if (hcnt_q[i] != HSAT) hcnt_d[i] = hcnt_q[i] + 1'b1;
            if (HOLD_EN && !fired_q[i] && (hcnt_q[i] == HFIRE)) begin
              hold_d[i]  = 1'b1;
              fired_d[i] = 1'b1;
            end
          end
        end
        StReleaseWait: begin
          // Bounce back to pressed keeps hcnt/fired so a hold cannot refire.
          if (s[i]) begin
            state_d[i] = StPressed;
          end else if (dcnt_q[i] == DLAST) begin
            state_d[i] = StIdle;
            level_d[i] = 1'b0;
            rel_d[i]   = 1'b1;
          end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
          end
        end
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= StIdle;
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
      end
      fired_q <= '0;
      level_q <= '0;
      press_q <= '0;
      rel_q   <= '0;
      hold_q  <= '0;
    end else begin
      sync1_q <= bus.nBtn;
      sync2_q <= sync1_q;
      for (int i = 0; i < NBTN; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
      end
      fired_q <= fired_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.level = level_q;
  assign bus.press = press_q;
  assign bus.rel   = rel_q;
  assign bus.hold  = hold_q;

endmodule

// File: tb/tb_panel_button_conditioner.sv
// Directed bench for panel_button_conditioner (NBTN=3, DEBOUNCE_CYCLES=4, LONG_CYCLES=20).
module tb_panel_button_conditioner;
  localparam int unsigned NBTN = 3;
  localparam int unsigned DEB  = 4;
  localparam int unsigned LONG = 20;

  logic clk    = 1'b0;
  logic nReset = 1'b1;
  always #20 clk = ~clk;

  panel_button_conditioner_if #(.NBTN(NBTN)) bus ();

  panel_button_conditioner #(
    .NBTN           (NBTN),
    .DEBOUNCE_CYCLES(DEB),
    .LONG_CYCLES    (LONG)
  ) dut (
    .clk   (clk),
    .nReset(nReset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp;
  logic [11:0] obs;
  // Packed as {level, press, rel, hold}.
  assign obs = {bus.level, bus.press, bus.rel, bus.hold};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.nBtn = 3'b111;
    #2 nReset = 1'b0;
    #1;
    exp = 12'b0;
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_assert: got %b want %b", obs, exp);
    end
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) nReset = 1'b1;
      tick();
      exp = 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL reset_idle step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_clean_press();
    bus.nBtn = 3'b110;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? 12'b0 : (i == 7) ? {3'b001, 3'b001, 6'b0} : {3'b001, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL clean_press step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_release_bounce();
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 3; i++) begin
      if (i == 3) bus.nBtn = 3'b110;
      tick();
      exp = {3'b001, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL release_bounce_glitch step %0d: got %b want %b", i, obs, exp);
      end
    end
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? {3'b001, 9'b0} : (i == 7) ? {6'b0, 3'b001, 3'b000} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL release_bounce step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_press_bounce();
    bus.nBtn = 3'b101;
    for (int i = 1; i <= 5; i++) begin
      if (i == 3) bus.nBtn = 3'b111;
      tick();
      exp = 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL press_bounce_glitch step %0d: got %b want %b", i, obs, exp);
      end
    end
    bus.nBtn = 3'b101;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? 12'b0 : (i == 7) ? {3'b010, 3'b010, 6'b0} : {3'b010, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL press_bounce step %0d: got %b want %b", i, obs, exp);
      end
    end
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? {3'b010, 9'b0} : (i == 7) ? {6'b0, 3'b010, 3'b000} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL press_bounce_release step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_long_hold();
    bus.nBtn = 3'b011;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = (i == 7) ? {3'b100, 3'b100, 6'b0} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL long_hold_press step %0d: got %b want %b", i, obs, exp);
      end
    end
    for (int k = 1; k <= 40; k++) begin
      tick();
      exp = {3'b100, 6'b0, (k == 20) ? 3'b100 : 3'b000};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL long_hold step %0d: got %b want %b", k, obs, exp);
      end
    end
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? {3'b100, 9'b0} : (i == 7) ? {6'b0, 3'b100, 3'b000} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL long_hold_release step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    bus.nBtn = 3'b101;
    for (int i = 1; i <= 7; i++) begin
      tick();
      exp = (i == 7) ? {3'b010, 3'b010, 6'b0} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL async_reset_setup step %0d: got %b want %b", i, obs, exp);
      end
    end
    // Channel 0 sits in the press-wait state with dcnt=2 after five edges.
    bus.nBtn = 3'b100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      exp = {3'b010, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL async_reset_wait step %0d: got %b want %b", i, obs, exp);
      end
    end
    #5 nReset = 1'b0;
    #1;
    exp = 12'b0;
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_reset_immediate: got %b want %b", obs, exp);
    end
    tick();
    tick();
    nReset = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? 12'b0 : (i == 7) ? {3'b011, 3'b011, 6'b0} : {3'b011, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL async_reset_relatency step %0d: got %b want %b", i, obs, exp);
      end
    end
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? {3'b011, 9'b0} : (i == 7) ? {6'b0, 3'b011, 3'b000} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL async_reset_release step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  task automatic test_simultaneous();
    bus.nBtn = 3'b000;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? 12'b0 : (i == 7) ? {3'b111, 3'b111, 6'b0} : {3'b111, 9'b0};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL simultaneous_press step %0d: got %b want %b", i, obs, exp);
      end
    end
    bus.nBtn = 3'b111;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp = (i < 7) ? {3'b111, 9'b0} : (i == 7) ? {6'b0, 3'b111, 3'b000} : 12'b0;
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL simultaneous_release step %0d: got %b want %b", i, obs, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release_bounce();
    test_press_bounce();
    test_long_hold();
    test_async_reset();
    test_simultaneous();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
